glb_arbiter: RTL and testbench
==============================

# glb_arbiter

- Shares the single GLB port (one bank select, one read port, one write port) between four requesters:
  - three read clients: ifmap, wght and psum-in;
  - one write client: psum-out.
- Sits between TOP_ctrl's data-movement sequencers and GLB, so ifmap/weight/psum fetches and psum write-back can overlap without each sequencer owning the bus.
- Round-robin grant, one GLB operation per cycle, one outstanding read per read client, registered per-client response buffer.

## Interface
- DATA_BITWIDTH, 32, GLB word width
- BANK_NUM, 3, number of GLB banks
- BANK_DEPTH, 512, words per bank
- BANK_W, clogb2(BANK_NUM-1), bank select width (2 at defaults)
- ADDR_W, clogb2(BANK_DEPTH-1), bank address width (9 at defaults)

Ports:
- i_clk  in  1  clock; one clock domain
- i_rst  in  1  reset; synchronous, active-high
- i_{ifmap,wght,psum}_req_valid  in  1  read request
- o_{ifmap,wght,psum}_req_ready  out  1  request accepted this cycle
- i_{ifmap,wght,psum}_req_bank  in  BANK_W  bank
- i_{ifmap,wght,psum}_req_addr  in  ADDR_W  address
- o_{ifmap,wght,psum}_rsp_valid  out  1  read data available
- i_{ifmap,wght,psum}_rsp_ready  in  1  client consumes data
- o_{ifmap,wght,psum}_rsp_data  out  DATA_BITWIDTH  read data
- i_wr_valid / o_wr_ready  in/out  1  psum write handshake
- i_wr_bank  in  BANK_W  write bank
- i_wr_addr  in  ADDR_W  write address
- i_wr_data  in  DATA_BITWIDTH  write data
- o_glb_bank_sel  out  BANK_W  to GLB i_bank_sel
- o_glb_re  out  1  to GLB i_re
- o_glb_we  out  1  to GLB i_we
- o_glb_ra  out  ADDR_W  to GLB i_ra
- o_glb_wa  out  ADDR_W  to GLB i_wa
- o_glb_wd  out  DATA_BITWIDTH  to GLB i_wd
- i_glb_rd  in  DATA_BITWIDTH  from GLB o_rd; valid the cycle after o_glb_re
- o_bank_err  out  1  sticky: request with bank >= BANK_NUM seen

## Operation
- Slots: 0 ifmap, 1 wght, 2 psum (read), 3 write.
- Eligibility:
  - A read slot is eligible when req_valid is high, it has no read in flight, and its rsp buffer is empty or is popped this cycle (rsp_valid & rsp_ready).
  - Slot 3 is eligible when i_wr_valid is high.
- Grant:
  - At most one grant per cycle.
  - Round-robin search starts at rr_ptr.
  - rr_ptr <= granted slot + 1 (mod 4), updated only on a grant.
  - rr_ptr resets to 0.
- The granted slot sees its req_ready / o_wr_ready high; the handshake completes in the same cycle. All other ready signals are low.
- GLB drive, combinational from the grant:
  - Read grant: o_glb_re=1, o_glb_bank_sel=req_bank, o_glb_ra=req_addr.
  - Write grant: o_glb_we=1, o_glb_bank_sel=wr_bank, o_glb_wa=wr_addr, o_glb_wd=wr_data.
  - No grant: re=we=0; bank_sel, ra, wa and wd are 0.
- Read in flight: a per-client flag, set on grant. On the next cycle i_glb_rd is captured into that client's rsp buffer and the flag clears.
- Rsp buffer: 1 entry. rsp_valid stays high until rsp_ready; rsp_data is held stable while valid.
- Out-of-range bank (>= BANK_NUM):
  - The request is still granted and handshaken, but re/we stay 0.
  - A read returns DATA_BITWIDTH'h0 with normal latency.
  - A write is dropped.
  - o_bank_err sets and stays high until i_rst.
- Reset mid-operation: in-flight flags and rsp buffers are discarded (no response is ever delivered for them) and rr_ptr is set to 0.

## Timing
- Reset values: every ready, rsp_valid and rsp_data is 0; o_glb_re and o_glb_we are 0 and all GLB address/data outputs are 0; o_bank_err is 0.
- While i_rst is high, all ready and GLB enable outputs are forced to 0 combinationally.
- Read latency:
  - Accept in cycle T.
  - o_glb_re high in T.
  - i_glb_rd sampled at the end of T+1.
  - rsp_valid high from T+2.
- Write: accept and o_glb_we both occur in cycle T; no response.
- Per-client read throughput: 1 per 2 cycles when rsp_ready is held high. The aggregate GLB port reaches 1 op/cycle with 2 or more active clients.
- A pop and a new grant for the same client may occur in the same cycle; the buffer refills at T+1 capture with no bubble.
- Requests must hold valid, bank, addr and data stable until ready.
- An ungranted eligible slot waits at most 3 grant cycles (4 cycles in total).

## Configuration
- GLB_ARB_WR_PRIORITY_EN
  - Defined: slot 3 (write) wins whenever i_wr_valid is high, ignoring rr_ptr. Read slots round-robin among themselves with a 3-slot pointer; write grants leave the pointer unchanged. Reads can starve under continuous writes.
  - Undefined: write is a normal 4th round-robin slot as described above.

## Test plan
- Single read: after reset, ifmap requests bank 0 addr 9'd5, with GLB bank 0 word 5 = 32'h1234 → req_ready in T, o_glb_re=1, o_glb_ra=5, bank_sel=0 in T; rsp_valid with data 32'h1234 at T+2.
- All three reads plus write valid continuously from reset, rsp_ready=1 → grant order ifmap, wght, psum, write, repeating (macro undefined). With the macro defined, write is granted every cycle and no read is granted.
- Back-pressure: wght rsp_ready=0 after the first response → wght rsp_data held, further wght requests not granted. Raise rsp_ready → the next wght grant occurs in the same cycle as the pop.
- Out-of-range: psum requests bank 2'd3 → granted, re=0, rsp_data=0 at T+2, o_bank_err=1 and stays high; a write to bank 3 gives we=0.
- Reset in T+1 of an outstanding ifmap read → rsp_valid never asserts. The first post-reset grant goes to ifmap when all slots request.
- Write then read the same address: write 32'hCAFE to bank 2 addr 9'd0, then psum reads bank 2 addr 0 → rsp_data 32'hCAFE.

Source files
------------

// File: rtl/glb_arbiter_if.sv
// Bundle between glb_arbiter and its neighbours: three read clients, the psum write client and the GLB port.
// The slave modport is the arbiter's view; the master modport is the view of whatever drives the clients and models GLB.
interface glb_arbiter_if #(
    parameter int DATA_BITWIDTH = 32,
    parameter int BANK_W        = 2,
    parameter int ADDR_W        = 9
);
    logic                     i_ifmap_req_valid, o_ifmap_req_ready;
    logic [BANK_W-1:0]        i_ifmap_req_bank;
    logic [ADDR_W-1:0]        i_ifmap_req_addr;
    logic                     o_ifmap_rsp_valid, i_ifmap_rsp_ready;
    logic [DATA_BITWIDTH-1:0] o_ifmap_rsp_data;

    logic                     i_wght_req_valid, o_wght_req_ready;
    logic [BANK_W-1:0]        i_wght_req_bank;
    logic [ADDR_W-1:0]        i_wght_req_addr;
    logic                     o_wght_rsp_valid, i_wght_rsp_ready;
    logic [DATA_BITWIDTH-1:0] o_wght_rsp_data;

    logic                     i_psum_req_valid, o_psum_req_ready;
    logic [BANK_W-1:0]        i_psum_req_bank;
    logic [ADDR_W-1:0]        i_psum_req_addr;
    logic                     o_psum_rsp_valid, i_psum_rsp_ready;
    logic [DATA_BITWIDTH-1:0] o_psum_rsp_data;

    logic                     i_wr_valid, o_wr_ready;
    logic [BANK_W-1:0]        i_wr_bank;
    logic [ADDR_W-1:0]        i_wr_addr;
    logic [DATA_BITWIDTH-1:0] i_wr_data;

    logic [BANK_W-1:0]        o_glb_bank_sel;
    logic                     o_glb_re, o_glb_we;
    logic [ADDR_W-1:0]        o_glb_ra, o_glb_wa;
    logic [DATA_BITWIDTH-1:0] o_glb_wd, i_glb_rd;
    logic                     o_bank_err;

    modport slave (
        input  i_ifmap_req_valid, i_ifmap_req_bank, i_ifmap_req_addr, i_ifmap_rsp_ready,
        output o_ifmap_req_ready, o_ifmap_rsp_valid, o_ifmap_rsp_data,
        input  i_wght_req_valid, i_wght_req_bank, i_wght_req_addr, i_wght_rsp_ready,
        output o_wght_req_ready, o_wght_rsp_valid, o_wght_rsp_data,
        input  i_psum_req_valid, i_psum_req_bank, i_psum_req_addr, i_psum_rsp_ready,
        output o_psum_req_ready, o_psum_rsp_valid, o_psum_rsp_data,
        input  i_wr_valid, i_wr_bank, i_wr_addr, i_wr_data,
        output o_wr_ready,
        output o_glb_bank_sel, o_glb_re, o_glb_we, o_glb_ra, o_glb_wa, o_glb_wd,
        input  i_glb_rd,
        output o_bank_err
    );

    modport master (
        output i_ifmap_req_valid, i_ifmap_req_bank, i_ifmap_req_addr, i_ifmap_rsp_ready,
        input  o_ifmap_req_ready, o_ifmap_rsp_valid, o_ifmap_rsp_data,
        output i_wght_req_valid, i_wght_req_bank, i_wght_req_addr, i_wght_rsp_ready,
        input  o_wght_req_ready, o_wght_rsp_valid, o_wght_rsp_data,
        output i_psum_req_valid, i_psum_req_bank, i_psum_req_addr, i_psum_rsp_ready,
        input  o_psum_req_ready, o_psum_rsp_valid, o_psum_rsp_data,
        output i_wr_valid, i_wr_bank, i_wr_addr, i_wr_data,
        input  o_wr_ready,
        input  o_glb_bank_sel, o_glb_re, o_glb_we, o_glb_ra, o_glb_wa, o_glb_wd,
        output i_glb_rd,
        input  o_bank_err
    );
endinterface

// File: rtl/glb_arbiter.sv
// Round-robin sharing of the single GLB port between ifmap/wght/psum readers (slots 0-2) and the psum writer (slot 3).
// Optional GLB_ARB_WR_PRIORITY_EN: the writer always wins, and the readers rotate among themselves.
module glb_arbiter #(
    parameter int DATA_BITWIDTH = 32,
    parameter int BANK_NUM      = 3,
    parameter int BANK_DEPTH    = 512,
    // $clog2(N) gives the bit count of N-1 for N >= 2, which is the width needed to hold indices 0..N-1.
    parameter int BANK_W        = $clog2(BANK_NUM),
    parameter int ADDR_W        = $clog2(BANK_DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    glb_arbiter_if.slave  bus
);
    logic [2:0]               rd_valid_s, rd_rsp_ready_s;
    logic [BANK_W-1:0]        slot_bank_s [4];
    logic [ADDR_W-1:0]        slot_addr_s [4];
    logic [3:0]               slot_oor_s, elig_s, gnt_oh_s;
    logic                     gnt_vld_s;
    logic [1:0]               gnt_idx_s;

    logic [2:0]               inflight_q, inflight_d, oor_q, oor_d, rsp_valid_q, rsp_valid_d;
    logic [DATA_BITWIDTH-1:0] rsp_data_q [3];
    logic [DATA_BITWIDTH-1:0] rsp_data_d [3];
    logic [1:0]               rr_ptr_q, rr_ptr_d;
    logic                     bank_err_q, bank_err_d;

    // Gather the per-slot request fields and work out which slots may be granted.
    always_comb begin
        rd_valid_s     = {bus.i_psum_req_valid, bus.i_wght_req_valid, bus.i_ifmap_req_valid};
        rd_rsp_ready_s = {bus.i_psum_rsp_ready, bus.i_wght_rsp_ready, bus.i_ifmap_rsp_ready};
        slot_bank_s[0] = bus.i_ifmap_req_bank;
        slot_bank_s[1] = bus.i_wght_req_bank;
        slot_bank_s[2] = bus.i_psum_req_bank;
        slot_bank_s[3] = bus.i_wr_bank;
        slot_addr_s[0] = bus.i_ifmap_req_addr;
        slot_addr_s[1] = bus.i_wght_req_addr;
        slot_addr_s[2] = bus.i_psum_req_addr;
        slot_addr_s[3] = bus.i_wr_addr;
        for (int i = 0; i < 4; i++) begin
            slot_oor_s[i] = (int'(slot_bank_s[i]) >= BANK_NUM);
        end
        // A reader may re-issue in the very cycle its full buffer is popped.
        for (int i = 0; i < 3; i++) begin
            elig_s[i] = ~i_rst & rd_valid_s[i] & ~inflight_q[i] & (~rsp_valid_q[i] | rd_rsp_ready_s[i]);
        end
        elig_s[3] = ~i_rst & bus.i_wr_valid;
    end

    // Pick at most one slot, searching onward from the round-robin pointer.
    always_comb begin
        gnt_vld_s = 1'b0;
        gnt_idx_s = 2'd0;
`ifdef GLB_ARB_WR_PRIORITY_EN
        if (elig_s[3]) begin
            gnt_vld_s = 1'b1;
            gnt_idx_s = 2'd3;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (!gnt_vld_s && elig_s[(int'(rr_ptr_q) + k) % 3]) begin
                    gnt_vld_s = 1'b1;
                    gnt_idx_s = 2'((int'(rr_ptr_q) + k) % 3);
                end else begin
                    gnt_idx_s = gnt_idx_s;
                end
            end
        end
`else
        for (int k = 0; k < 4; k++) begin
            if (!gnt_vld_s && elig_s[(int'(rr_ptr_q) + k) % 4]) begin
                gnt_vld_s = 1'b1;
                gnt_idx_s = 2'((int'(rr_ptr_q) + k) % 4);
            end else begin
                gnt_idx_s = gnt_idx_s;
            end
        end
`endif
        gnt_oh_s = gnt_vld_s ? (4'b0001 << gnt_idx_s) : 4'b0000;
    end

    // Drive GLB from the grant; an out-of-range bank is handshaken but never reaches GLB.
    always_comb begin
        bus.o_glb_bank_sel = {BANK_W{1'b0}};
        bus.o_glb_re       = 1'b0;
        bus.o_glb_we       = 1'b0;
        bus.o_glb_ra       = {ADDR_W{1'b0}};
        bus.o_glb_wa       = {ADDR_W{1'b0}};
        bus.o_glb_wd       = {DATA_BITWIDTH{1'b0}};
        if (gnt_vld_s && !slot_oor_s[gnt_idx_s]) begin
            bus.o_glb_bank_sel = slot_bank_s[gnt_idx_s];
            if (gnt_idx_s == 2'd3) begin
                bus.o_glb_we = 1'b1;
                bus.o_glb_wa = slot_addr_s[3];
                bus.o_glb_wd = bus.i_wr_data;
            end else begin
                bus.o_glb_re = 1'b1;
                bus.o_glb_ra = slot_addr_s[gnt_idx_s];
            end
        end else begin
            bus.o_glb_re = 1'b0;
        end
    end

    // Next state: capture read data one cycle after the grant, pop on rsp_ready, advance the pointer.
    always_comb begin
        inflight_d  = gnt_oh_s[2:0];
        oor_d       = oor_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        bank_err_d  = bank_err_q | (gnt_vld_s & slot_oor_s[gnt_idx_s]);
        for (int i = 0; i < 3; i++) begin
            if (gnt_oh_s[i]) begin
                oor_d[i] = slot_oor_s[i];
            end else begin
                oor_d[i] = oor_q[i];
            end
            if (inflight_q[i]) begin
                rsp_valid_d[i] = 1'b1;
                rsp_data_d[i]  = oor_q[i] ? {DATA_BITWIDTH{1'b0}} : bus.i_glb_rd;
            end else if (rsp_valid_q[i] && rd_rsp_ready_s[i]) begin
                rsp_valid_d[i] = 1'b0;
            end else begin
                rsp_valid_d[i] = rsp_valid_q[i];
            end
        end
`ifdef GLB_ARB_WR_PRIORITY_EN
        if (gnt_vld_s && (gnt_idx_s != 2'd3)) begin
            rr_ptr_d = (gnt_idx_s == 2'd2) ? 2'd0 : (gnt_idx_s + 2'd1);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
`else
        if (gnt_vld_s) begin
            rr_ptr_d = gnt_idx_s + 2'd1;
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
`endif
    end

    // State registers; reset discards in-flight reads and buffered responses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            inflight_q  <= 3'b000;
            oor_q       <= 3'b000;
            rsp_valid_q <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                rsp_data_q[i] <= {DATA_BITWIDTH{1'b0}};
            end
            rr_ptr_q    <= 2'd0;
            bank_err_q  <= 1'b0;
        end else begin
            inflight_q  <= inflight_d;
            oor_q       <= oor_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rr_ptr_q    <= rr_ptr_d;
            bank_err_q  <= bank_err_d;
        end
    end

    assign bus.o_ifmap_req_ready = gnt_oh_s[0];
    assign bus.o_wght_req_ready  = gnt_oh_s[1];
    assign bus.o_psum_req_ready  = gnt_oh_s[2];
    assign bus.o_wr_ready        = gnt_oh_s[3];
    assign bus.o_ifmap_rsp_valid = rsp_valid_q[0];
    assign bus.o_wght_rsp_valid  = rsp_valid_q[1];
    assign bus.o_psum_rsp_valid  = rsp_valid_q[2];
    assign bus.o_ifmap_rsp_data  = rsp_data_q[0];
    assign bus.o_wght_rsp_data   = rsp_data_q[1];
    assign bus.o_psum_rsp_data   = rsp_data_q[2];
    assign bus.o_bank_err        = bank_err_q;
endmodule

// File: tb/tb_glb_arbiter.sv
// Directed bench for glb_arbiter: a vector table for grant order plus hand sequences for latency, back-pressure,
// out-of-range banks, write-then-read and reset during a read. GLB itself is a small behavioural memory.
module tb_glb_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    glb_arbiter_if #(.DATA_BITWIDTH(32), .BANK_W(2), .ADDR_W(9)) bus ();

    glb_arbiter #(.DATA_BITWIDTH(32), .BANK_NUM(3), .BANK_DEPTH(512)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // GLB model: one-cycle read latency, a few words seeded while reset is asserted.
    logic [31:0] mem [0:3][0:511];
    always @(posedge clk) begin
        if (rst) begin
            mem[0][5]    <= 32'h0000_1234;
            mem[1][7]    <= 32'hBEEF_0001;
            mem[1][8]    <= 32'hBEEF_0002;
            bus.i_glb_rd <= 32'hDEAD_DEAD;
        end else begin
            if (bus.o_glb_we) mem[bus.o_glb_bank_sel][bus.o_glb_wa] <= bus.o_glb_wd;
            if (bus.o_glb_re) bus.i_glb_rd <= mem[bus.o_glb_bank_sel][bus.o_glb_ra];
        end
    end

    typedef struct {
        logic [3:0] valid;      // {wr, psum, wght, ifmap}
        logic [3:0] exp_ready;  // {wr, psum, wght, ifmap}
        logic       exp_re;
        logic       exp_we;
        logic [1:0] exp_bank;
    } vec_t;
    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] readies();
        return {bus.o_wr_ready, bus.o_psum_req_ready, bus.o_wght_req_ready, bus.o_ifmap_req_ready};
    endfunction

    task automatic set_valid(input logic [3:0] v);
        bus.i_ifmap_req_valid = v[0];
        bus.i_wght_req_valid  = v[1];
        bus.i_psum_req_valid  = v[2];
        bus.i_wr_valid        = v[3];
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        set_valid(4'b0000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        set_valid(4'b0000);
        bus.i_ifmap_req_bank = 2'd0; bus.i_ifmap_req_addr = 9'd1; bus.i_ifmap_rsp_ready = 1'b0;
        bus.i_wght_req_bank  = 2'd1; bus.i_wght_req_addr  = 9'd2; bus.i_wght_rsp_ready  = 1'b0;
        bus.i_psum_req_bank  = 2'd2; bus.i_psum_req_addr  = 9'd3; bus.i_psum_rsp_ready  = 1'b0;
        bus.i_wr_bank = 2'd1; bus.i_wr_addr = 9'd4; bus.i_wr_data = 32'h0000_0077;

        // Grant order with every slot busy, then a few partial patterns including an idle cycle.
`ifdef GLB_ARB_WR_PRIORITY_EN
        for (int i = 0; i < 8; i++) vecs[i] = '{4'b1111, 4'b1000, 1'b0, 1'b1, 2'd1};
        vecs[8]  = '{4'b1010, 4'b1000, 1'b0, 1'b1, 2'd1};
        vecs[9]  = '{4'b1010, 4'b1000, 1'b0, 1'b1, 2'd1};
`else
        for (int i = 0; i < 8; i += 4) begin
            vecs[i]   = '{4'b1111, 4'b0001, 1'b1, 1'b0, 2'd0};
            vecs[i+1] = '{4'b1111, 4'b0010, 1'b1, 1'b0, 2'd1};
            vecs[i+2] = '{4'b1111, 4'b0100, 1'b1, 1'b0, 2'd2};
            vecs[i+3] = '{4'b1111, 4'b1000, 1'b0, 1'b1, 2'd1};
        end
        vecs[8]  = '{4'b1010, 4'b0010, 1'b1, 1'b0, 2'd1};
        vecs[9]  = '{4'b1010, 4'b1000, 1'b0, 1'b1, 2'd1};
`endif
        vecs[10] = '{4'b0001, 4'b0001, 1'b1, 1'b0, 2'd0};
        vecs[11] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0};

        // Reset state: readies and enables forced low even with every slot requesting.
        @(negedge clk);
        set_valid(4'b1111);
        @(negedge clk);
        #1;
        chk("rst_ready", 32'(readies()), 32'h0);
        chk("rst_re_we", 32'({bus.o_glb_re, bus.o_glb_we}), 32'h0);
        chk("rst_glb_addr", 32'({bus.o_glb_bank_sel, bus.o_glb_ra, bus.o_glb_wa}), 32'h0);
        chk("rst_glb_wd", bus.o_glb_wd, 32'h0);
        chk("rst_rsp_valid", 32'({bus.o_psum_rsp_valid, bus.o_wght_rsp_valid, bus.o_ifmap_rsp_valid}), 32'h0);
        chk("rst_rsp_data", bus.o_ifmap_rsp_data | bus.o_wght_rsp_data | bus.o_psum_rsp_data, 32'h0);
        chk("rst_bank_err", 32'(bus.o_bank_err), 32'h0);
        do_reset();

        bus.i_ifmap_rsp_ready = 1'b1; bus.i_wght_rsp_ready = 1'b1; bus.i_psum_rsp_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            set_valid(vecs[i].valid);
            #1;
            chk($sformatf("vec%0d_ready", i), 32'(readies()), 32'(vecs[i].exp_ready));
            chk($sformatf("vec%0d_re", i), 32'(bus.o_glb_re), 32'(vecs[i].exp_re));
            chk($sformatf("vec%0d_we", i), 32'(bus.o_glb_we), 32'(vecs[i].exp_we));
            chk($sformatf("vec%0d_bank", i), 32'(bus.o_glb_bank_sel), 32'(vecs[i].exp_bank));
        end
        repeat (3) @(negedge clk);
        bus.i_ifmap_rsp_ready = 1'b0; bus.i_wght_rsp_ready = 1'b0; bus.i_psum_rsp_ready = 1'b0;
        do_reset();

        // Single read: ifmap bank 0 addr 5, data two cycles later.
        @(negedge clk);
        bus.i_ifmap_req_addr = 9'd5; bus.i_ifmap_req_valid = 1'b1;
        #1;
        chk("rd_ready", 32'(bus.o_ifmap_req_ready), 32'h1);
        chk("rd_re", 32'(bus.o_glb_re), 32'h1);
        chk("rd_ra", 32'(bus.o_glb_ra), 32'd5);
        chk("rd_bank", 32'(bus.o_glb_bank_sel), 32'd0);
        @(negedge clk);
        bus.i_ifmap_req_valid = 1'b0;
        #1;
        chk("rd_t1_valid", 32'(bus.o_ifmap_rsp_valid), 32'h0);
        @(negedge clk);
        #1;
        chk("rd_t2_valid", 32'(bus.o_ifmap_rsp_valid), 32'h1);
        chk("rd_t2_data", bus.o_ifmap_rsp_data, 32'h0000_1234);
        bus.i_ifmap_rsp_ready = 1'b1;
        @(negedge clk);
        bus.i_ifmap_rsp_ready = 1'b0;
        #1;
        chk("rd_popped", 32'(bus.o_ifmap_rsp_valid), 32'h0);

        // Back-pressure on wght: buffer held, no re-grant until the pop, then grant in the pop cycle.
        @(negedge clk);
        bus.i_wght_req_bank = 2'd1; bus.i_wght_req_addr = 9'd7; bus.i_wght_req_valid = 1'b1;
        #1;
        chk("bp_grant0", 32'(bus.o_wght_req_ready), 32'h1);
        chk("bp_ra0", 32'(bus.o_glb_ra), 32'd7);
        @(negedge clk);
        bus.i_wght_req_addr = 9'd8;
        #1;
        chk("bp_inflight_ready", 32'(bus.o_wght_req_ready), 32'h0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("bp_full%0d_valid", c), 32'(bus.o_wght_rsp_valid), 32'h1);
            chk($sformatf("bp_full%0d_data", c), bus.o_wght_rsp_data, 32'hBEEF_0001);
            chk($sformatf("bp_full%0d_ready", c), 32'(bus.o_wght_req_ready), 32'h0);
        end
        @(negedge clk);
        bus.i_wght_rsp_ready = 1'b1;
        #1;
        chk("bp_pop_grant", 32'(bus.o_wght_req_ready), 32'h1);
        chk("bp_pop_ra", 32'(bus.o_glb_ra), 32'd8);
        @(negedge clk);
        bus.i_wght_req_valid = 1'b0; bus.i_wght_rsp_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("bp_refill_valid", 32'(bus.o_wght_rsp_valid), 32'h1);
        chk("bp_refill_data", bus.o_wght_rsp_data, 32'hBEEF_0002);
        bus.i_wght_rsp_ready = 1'b1;
        @(negedge clk);
        bus.i_wght_rsp_ready = 1'b0;

        // Out-of-range bank: read returns zero, write dropped, error sticks.
        @(negedge clk);
        bus.i_psum_req_bank = 2'd3; bus.i_psum_req_addr = 9'd0; bus.i_psum_req_valid = 1'b1;
        #1;
        chk("oor_rd_ready", 32'(bus.o_psum_req_ready), 32'h1);
        chk("oor_rd_re", 32'(bus.o_glb_re), 32'h0);
        @(negedge clk);
        bus.i_psum_req_valid = 1'b0;
        #1;
        chk("oor_err_set", 32'(bus.o_bank_err), 32'h1);
        @(negedge clk);
        #1;
        chk("oor_rsp_valid", 32'(bus.o_psum_rsp_valid), 32'h1);
        chk("oor_rsp_data", bus.o_psum_rsp_data, 32'h0);
        bus.i_psum_rsp_ready = 1'b1;
        @(negedge clk);
        bus.i_psum_rsp_ready = 1'b0;
        bus.i_wr_bank = 2'd3; bus.i_wr_addr = 9'd0; bus.i_wr_data = 32'h0000_0005; bus.i_wr_valid = 1'b1;
        #1;
        chk("oor_wr_ready", 32'(bus.o_wr_ready), 32'h1);
        chk("oor_wr_we", 32'(bus.o_glb_we), 32'h0);
        chk("oor_err_sticky", 32'(bus.o_bank_err), 32'h1);

        // Write 0xCAFE to bank 2 addr 0, then read it back through psum.
        @(negedge clk);
        bus.i_wr_bank = 2'd2; bus.i_wr_data = 32'h0000_CAFE;
        #1;
        chk("wr_ready", 32'(bus.o_wr_ready), 32'h1);
        chk("wr_we", 32'(bus.o_glb_we), 32'h1);
        chk("wr_bank_wa", 32'({bus.o_glb_bank_sel, bus.o_glb_wa}), 32'({2'd2, 9'd0}));
        chk("wr_wd", bus.o_glb_wd, 32'h0000_CAFE);
        @(negedge clk);
        bus.i_wr_valid = 1'b0;
        bus.i_psum_req_bank = 2'd2; bus.i_psum_req_addr = 9'd0; bus.i_psum_req_valid = 1'b1;
        #1;
        chk("wr_rd_re", 32'(bus.o_glb_re), 32'h1);
        @(negedge clk);
        bus.i_psum_req_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("wr_rd_data", bus.o_psum_rsp_data, 32'h0000_CAFE);
        bus.i_psum_rsp_ready = 1'b1;
        @(negedge clk);
        bus.i_psum_rsp_ready = 1'b0;

        // Reset in the cycle after an ifmap grant: that response never appears.
        @(negedge clk);
        bus.i_ifmap_req_addr = 9'd5; bus.i_ifmap_req_valid = 1'b1;
        #1;
        chk("mid_grant", 32'(bus.o_ifmap_req_ready), 32'h1);
        @(negedge clk);
        bus.i_ifmap_req_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_err_clr", 32'(bus.o_bank_err), 32'h0);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("mid_no_rsp%0d", c), 32'(bus.o_ifmap_rsp_valid), 32'h0);
            @(negedge clk);
            #1;
        end
        bus.i_wr_bank = 2'd0; bus.i_wr_addr = 9'd10;
        bus.i_psum_req_bank = 2'd2; bus.i_psum_req_addr = 9'd3;
        set_valid(4'b1111);
        #1;
`ifdef GLB_ARB_WR_PRIORITY_EN
        chk("post_rst_first", 32'(readies()), 32'h8);
`else
        chk("post_rst_first", 32'(readies()), 32'h1);
`endif
        @(negedge clk);
        set_valid(4'b0000);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
